ui_uart_baud_gen_prog: RTL
==========================

// Module: ui_uart_baud_gen_prog
// PURPOSE
//  Runtime-programmable oversampled baud-enable generator for ui_uart_rx/ui_uart_tx.
//  Divides clk by a fixed-point divisor (integer + optional fraction) to make baud_os_en.
//  Also makes a 1x bit enable, baud_bit_en, every OVERSAMPLE os ticks.
//  The baud rate can change without re-synthesis; the change is glitch-free at period boundaries.
// PARAMETERS
//  BAUD_RATE   500_000      reset-time baud rate (bps)
//  CLOCK_RATE  400_000_000  clk frequency (Hz)
//  OVERSAMPLE  16           os ticks per bit; power of 2, 4..32
//  INT_WID     16           divisor integer width
//  FRAC_WID    8            divisor fraction width (used only with UI_UART_BAUD_FRAC_EN)
// PORTS
//  clk          in   1         system clock
//  rst          in   1         synchronous, active-high reset
//  enable       in   1         run generator; low = hold idle
//  div_load     in   1         1-cycle strobe: capture div_int/div_frac into shadow
//  div_int      in   INT_WID   new integer divisor (clk cycles per os tick)
//  div_frac     in   FRAC_WID  new fractional divisor, units of 2^-FRAC_WID
//  baud_os_en   out  1         registered 1-cycle oversampled enable
//  baud_bit_en  out  1         registered 1-cycle bit enable, coincident with an os pulse
//  div_active   out  INT_WID   integer divisor currently in use
// BEHAVIOUR
//  Reset values: baud_os_en=0, baud_bit_en=0, os_cnt=0, frac_acc=0, shadow_pending=0.
//   div_active = DEF_INT = round(CLOCK_RATE/(OVERSAMPLE*BAUD_RATE)).
//   Active fraction = DEF_FRAC, the rounded fractional part. Down-counter = DEF_INT-1.
//  Period P = div_active + carry.
//   carry = carry-out of frac_acc + frac_active (FRAC_WID-bit wrap), evaluated at each wrap.
//  Down-counter counts P-1..0. At 0 it reloads.
//   baud_os_en is high in the cycle after the counter reaches 0 (registered, next-is-zero lookahead).
//  First baud_os_en comes exactly P clocks after the first rising edge with enable=1.
//   Subsequent pulses are spaced P clocks apart.
//  os_cnt (clog2(OVERSAMPLE) bits) increments on each os pulse and wraps.
//   baud_bit_en is high together with the os pulse where os_cnt wraps OVERSAMPLE-1 -> 0.
//   The first bit pulse is the OVERSAMPLE-th os pulse.
//  div_load: captures inputs into the shadow and sets pending.
//   The shadow is applied at the next wrap, so the current period is never cut short.
//   If div_load coincides with the wrap, the new value governs the period that starts at that wrap.
//   Back-to-back loads: the last one wins.
//   Applying a load also clears frac_acc.
//  Clamp: div_int < 2 is stored as 2. This guarantees pulses are never adjacent and never stuck high.
//  enable=0: counter is held at div_active-1; os_cnt and frac_acc are cleared; outputs are 0.
//   A pending load is applied immediately.
//   On re-enable, the timing is the same as after reset (first pulse P clocks later).
//  rst mid-operation: all state returns to reset values on the next edge; any pending load is dropped.
//  Widths: frac_acc FRAC_WID bits, wrap-around is intended. The counter is INT_WID bits.
// CONFIGURATION
//  UI_UART_BAUD_FRAC_EN defined: fractional accumulator, div_frac and DEF_FRAC are all used.
//   Average period = div_int + div_frac/2^FRAC_WID.
//  Not defined: the fraction logic is removed, div_frac is ignored, and P = div_active always.
//   DEF_INT still uses the rounded division.
// STRUCTURE
//  Package ui_uart_pkg:
//   - function calc_div_fixed(clock, baud, os) -> {int, frac}, 64-bit intermediate, round-half-up
//   - typedef div_int_t / div_frac_t
//   - OVERSAMPLE legality check constant
//  Sub-module ui_uart_os_div: divides baud_os_en by OVERSAMPLE into baud_bit_en (registered).
//  The top level holds the shadow register, the down-counter and the fractional accumulator.
// TESTING
//  1 Defaults (400MHz, 500k, 16), enable=1:
//     baud_os_en every 50 clks; baud_bit_en every 800 clks; div_active=50.
//  2 FRAC_EN, FRAC_WID=8, load div_int=10, div_frac=0x80:
//     periods alternate 10/11; 256 os pulses take exactly 2688 clks. Without the macro: all 10.
//  3 Load div_int=20 mid-period (counter=30, div=50):
//     the current period finishes at 50; the next period is 20; div_active updates at the wrap.
//  4 Load issued on the exact wrap cycle: the period starting there is the new value.
//     Two loads (30, then 40) inside one period: 40 is applied.
//  5 Load div_int=0 or 1: div_active=2; pulses every 2 clks, never high on consecutive cycles.
//  6 enable low for 7 clks mid-bit, then high:
//     outputs stay 0 while low; the first os pulse comes P clks after re-enable;
//     the bit pulse comes after 16 os pulses.
//     rst during a pending load: the default divisor is restored.

Source files
------------

// File: rtl/ui_uart_baud_gen_prog_pkg.sv
// Shared types and elaboration helpers for the programmable UART baud generator.
// Holds the fixed-point divisor calculation and the OVERSAMPLE legality check.
package ui_uart_pkg;

  localparam int unsigned DIV_INT_W  = 16;
  localparam int unsigned DIV_FRAC_W = 8;

  typedef logic [DIV_INT_W-1:0]  div_int_t;
  typedef logic [DIV_FRAC_W-1:0] div_frac_t;

  typedef struct packed {
    logic [31:0] int_part;
    logic [31:0] frac_part;
  } div_fixed_t;

  // OVERSAMPLE must be a power of two in 4..32
  function automatic bit os_legal(input int unsigned os);
    return (os >= 32'd4) && (os <= 32'd32) && ((os & (os - 32'd1)) == 32'd0);
  endfunction

  // clock/(os*baud) in fixed point with frac_wid fraction bits, rounded half-up
  function automatic div_fixed_t calc_div_fixed(input longint unsigned clock,
                                                input longint unsigned baud,
                                                input longint unsigned os,
                                                input int unsigned     frac_wid);
    longint unsigned den;
    longint unsigned q;
    div_fixed_t      r;
    den         = os * baud;
    q           = ((clock << frac_wid) + (den >> 1)) / den;
    r.int_part  = 32'(q >> frac_wid);
    r.frac_part = 32'(q & ((64'd1 << frac_wid) - 64'd1));
    return r;
  endfunction

endpackage

// File: rtl/ui_uart_baud_gen_prog_os_div.sv
// Divides the oversampled enable by OVERSAMPLE into a registered 1x bit enable
// that coincides with the os pulse on which the os counter wraps.
module ui_uart_os_div #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic tick_i,
  output logic bit_en_o
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] os_cnt_q;
  logic          bit_en_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      os_cnt_q <= '0;
      bit_en_q <= 1'b0;
    end else begin
      if (tick_i) os_cnt_q <= os_cnt_q + CW'(1);
      bit_en_q <= tick_i && (os_cnt_q == CW'(OVERSAMPLE - 1));
    end
  end

  assign bit_en_o = bit_en_q;

endmodule

// File: rtl/ui_uart_baud_gen_prog.sv
// Runtime-programmable oversampled baud enable generator with shadowed divisor.
// Define UI_UART_BAUD_FRAC_EN to enable the fractional divisor accumulator.
module ui_uart_baud_gen_prog
  import ui_uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 500_000,
  parameter int unsigned CLOCK_RATE = 400_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned INT_WID    = 16,
  parameter int unsigned FRAC_WID   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                div_load,
  input  logic [INT_WID-1:0]  div_int,
  input  logic [FRAC_WID-1:0] div_frac,
  output logic                baud_os_en,
  output logic                baud_bit_en,
  output logic [INT_WID-1:0]  div_active
);

`ifdef UI_UART_BAUD_FRAC_EN
  localparam int unsigned FRAC_USED = FRAC_WID;
`else
  localparam int unsigned FRAC_USED = 0;
`endif

  localparam div_fixed_t DEF_FIX = calc_div_fixed(64'(CLOCK_RATE), 64'(BAUD_RATE),
                                                  64'(OVERSAMPLE), FRAC_USED);
  localparam logic [INT_WID-1:0] DEF_INT = (DEF_FIX.int_part < 32'd2) ? INT_WID'(2)
                                                                      : INT_WID'(DEF_FIX.int_part);
  localparam bit OS_LEGAL = os_legal(OVERSAMPLE);

  generate
    if (!OS_LEGAL) begin : g_os_illegal
      $error("OVERSAMPLE must be a power of 2 in 4..32");
    end
  endgenerate

  // Divisors below 2 would make pulses adjacent or stuck high
  function automatic logic [INT_WID-1:0] clamp_int(input logic [INT_WID-1:0] v);
    return (v < INT_WID'(2)) ? INT_WID'(2) : v;
  endfunction

  logic [INT_WID-1:0] cnt_q, cnt_d;
  logic [INT_WID-1:0] div_act_q, div_act_d;
  logic [INT_WID-1:0] shd_int_q, shd_int_d;
  logic               pend_q, pend_d;
  logic               os_en_q, os_en_d;
  logic               apply;
  logic               carry;

`ifdef UI_UART_BAUD_FRAC_EN
  localparam logic [FRAC_WID-1:0] DEF_FRAC = FRAC_WID'(DEF_FIX.frac_part);
  logic [FRAC_WID-1:0] frac_act_q, frac_act_d;
  logic [FRAC_WID-1:0] frac_acc_q, frac_acc_d;
  logic [FRAC_WID-1:0] shd_frac_q, shd_frac_d;
  logic [FRAC_WID-1:0] acc_base;
  logic [FRAC_WID:0]   frac_sum;
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
`endif

  // Next-state: shadow capture, apply at wrap (or at once while idle), period reload
  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    pend_d    = pend_q;
    os_en_d   = 1'b0;
    carry     = 1'b0;
    shd_int_d = div_load ? clamp_int(div_int) : shd_int_q;
    apply     = div_load | pend_q;
`ifdef UI_UART_BAUD_FRAC_EN
    frac_act_d = frac_act_q;
    frac_acc_d = frac_acc_q;
    shd_frac_d = div_load ? div_frac : shd_frac_q;
    acc_base   = frac_acc_q;
    frac_sum   = '0;
`endif
    if (!enable) begin
      if (apply) begin
        div_act_d = shd_int_d;
`ifdef UI_UART_BAUD_FRAC_EN
        frac_act_d = shd_frac_d;
`endif
      end
      pend_d = 1'b0;
      cnt_d  = div_act_d - INT_WID'(1);
`ifdef UI_UART_BAUD_FRAC_EN
      frac_acc_d = '0;
`endif
    end else if (cnt_q == '0) begin
      if (apply) begin
        div_act_d = shd_int_d;
        pend_d    = 1'b0;
`ifdef UI_UART_BAUD_FRAC_EN
        frac_act_d = shd_frac_d;
        acc_base   = '0;
`endif
      end
`ifdef UI_UART_BAUD_FRAC_EN
      frac_sum   = (FRAC_WID+1)'(acc_base) + (FRAC_WID+1)'(frac_act_d);
      carry      = frac_sum[FRAC_WID];
      frac_acc_d = frac_sum[FRAC_WID-1:0];
`endif
      cnt_d   = div_act_d + INT_WID'(carry) - INT_WID'(1);
      os_en_d = 1'b1;
    end else begin
      cnt_d = cnt_q - INT_WID'(1);
      if (div_load) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= DEF_INT - INT_WID'(1);
      div_act_q <= DEF_INT;
      shd_int_q <= DEF_INT;
      pend_q    <= 1'b0;
      os_en_q   <= 1'b0;
`ifdef UI_UART_BAUD_FRAC_EN
      frac_act_q <= DEF_FRAC;
      frac_acc_q <= '0;
      shd_frac_q <= DEF_FRAC;
`endif
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      shd_int_q <= shd_int_d;
      pend_q    <= pend_d;
      os_en_q   <= os_en_d;
`ifdef UI_UART_BAUD_FRAC_EN
      frac_act_q <= frac_act_d;
      frac_acc_q <= frac_acc_d;
      shd_frac_q <= shd_frac_d;
`endif
    end
  end

  ui_uart_os_div #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_os_div (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (~enable),
    .tick_i   (os_en_d),
    .bit_en_o (baud_bit_en)
  );

  assign baud_os_en = os_en_q;
  assign div_active = div_act_q;

endmodule
